// File: rtl/onchip_mem_bist_master.sv
// Write-then-read memory BIST master for a zero-wait Avalon-MM slave.
// Pattern is seed+i at base+i; read data is checked one cycle after each read.
module onchip_mem_bist_master #(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  localparam bit LAT_OK = (READ_LATENCY == 1);

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   cnt_q;
  logic [31:0]       seed_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic              cs_q;
  logic              wr_q;
  logic [31:0]       wd_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [15:0]       err_q;
  logic [ADDR_W-1:0] ffa_q;
  logic              fail_seen_q;
  logic              rd_vld_q;
  logic [31:0]       rd_exp_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              chk_vld_q;
  logic [31:0]       chk_exp_q;
  logic [ADDR_W-1:0] chk_addr_q;

  logic              wrap_d;
  logic [ADDR_W:0]   idx_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [31:0]       cmd_data_d;
  logic              mismatch_d;
  logic              abort_d;

  // Index restarts at 0 on the cycle a phase finishes its last command
  always_comb begin
    wrap_d     = (idx_q == cnt_q);
    idx_d      = wrap_d ? '0 : idx_q;
    cmd_addr_d = base_q + idx_d[ADDR_W-1:0];
    cmd_data_d = seed_q + 32'(idx_d);
    mismatch_d = LAT_OK && chk_vld_q && (readdata != chk_exp_q);
    abort_d    = abort && (state_q == S_WRITE || state_q == S_READ ||
                           state_q == S_DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ffa_q       <= '0;
      fail_seen_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_exp_q    <= '0;
      rd_addr_q   <= '0;
      chk_vld_q   <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
    end else begin
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      be_q       <= '0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      chk_vld_q  <= rd_vld_q;
      chk_exp_q  <= rd_exp_q;
      chk_addr_q <= rd_addr_q;
      if (mismatch_d) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (!fail_seen_q) begin
          ffa_q       <= chk_addr_q;
          fail_seen_q <= 1'b1;
        end
      end
      if (abort_d) begin
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        pass_q    <= 1'b0;
        chk_vld_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: if (start) begin
            base_q      <= base;
            cnt_q       <= count;
            seed_q      <= seed;
            err_q       <= '0;
            ffa_q       <= '0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            busy_q      <= 1'b1;
            if (count == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_WRITE;
              cs_q    <= 1'b1;
              wr_q    <= 1'b1;
              be_q    <= 4'hF;
              addr_q  <= base;
              wd_q    <= seed;
              idx_q   <= {{ADDR_W{1'b0}}, 1'b1};
            end
          end
          S_WRITE: begin
            cs_q   <= 1'b1;
            be_q   <= 4'hF;
            addr_q <= cmd_addr_d;
            idx_q  <= idx_d + 1'b1;
            if (wrap_d) begin
              state_q   <= S_READ;
              rd_vld_q  <= 1'b1;
              rd_exp_q  <= cmd_data_d;
              rd_addr_q <= cmd_addr_d;
            end else begin
              wr_q <= 1'b1;
              wd_q <= cmd_data_d;
            end
          end
          S_READ: begin
            if (wrap_d) begin
              state_q <= S_DRAIN;
            end else begin
              cs_q      <= 1'b1;
              be_q      <= 4'hF;
              addr_q    <= cmd_addr_d;
              idx_q     <= idx_d + 1'b1;
              rd_vld_q  <= 1'b1;
              rd_exp_q  <= cmd_data_d;
              rd_addr_q <= cmd_addr_d;
            end
          end
          S_DRAIN: state_q <= S_DONE;
          S_DONE: begin
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0);
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign address         = addr_q;
  assign byteenable      = be_q;
  assign chipselect      = cs_q;
  assign write           = wr_q;
  assign writedata       = wd_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// Directed bench: zero-wait memory model with optional corrupt word,
// bus command log, and per-scenario tasks with inline checks.
module tb_onchip_mem_bist_master;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [31:0]   seed;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_fail_addr;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic          lw [$];
  logic [AW-1:0] la [$];
  logic [31:0]   ld [$];
  logic [3:0]    lb [$];

  onchip_mem_bist_master #(.ADDR_W(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base(base), .count(count), .seed(seed),
    .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(readdata),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_fail_addr(first_fail_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_seen++;
    if (chipselect) begin
      lw.push_back(write);
      la.push_back(address);
      ld.push_back(writedata);
      lb.push_back(byteenable);
      if (write) mem[address] <= writedata;
      else if (corrupt_en && address == corrupt_addr)
        readdata <= 32'hDEAD_BEEF;
      else readdata <= mem[address];
    end
  end

  task automatic launch(input logic [AW-1:0] b, input int n,
                        input logic [31:0] s);
    @(negedge clk);
    base = b; count = (AW+1)'(n); seed = s; start = 1'b1;
    lw.delete(); la.delete(); ld.delete(); lb.delete();
    done_seen = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int c);
    c = 0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      failures++;
      $display("FAIL %s: done timeout after %0d cycles", nm, c);
    end
  endtask

  task automatic check_log(input string nm, input logic [AW-1:0] b,
                           input int n, input logic [31:0] s);
    checks++;
    if (lw.size() !== 2*n) begin
      failures++;
      $display("FAIL %s log size: got %0d want %0d", nm, lw.size(), 2*n);
    end else begin
      for (int i = 0; i < 2*n; i++) begin
        logic          ew;
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        ew = (i < n);
        ea = b + AW'(ew ? i : i - n);
        ed = ew ? s + 32'(i) : 32'h0;
        checks++;
        if (lw[i] !== ew || la[i] !== ea || ld[i] !== ed || lb[i] !== 4'hF) begin
          failures++;
          $display("FAIL %s cmd%0d: got w=%0b a=%h d=%h be=%h want w=%0b a=%h d=%h be=F",
                   nm, i, lw[i], la[i], ld[i], lb[i], ew, ea, ed);
        end
      end
    end
  endtask

  task automatic check_idle_outs(input string nm);
    checks++;
    if ({busy, done, pass, chipselect, write} !== 5'b0 ||
        address !== '0 || writedata !== '0 || byteenable !== '0 ||
        error_count !== '0 || first_fail_addr !== '0) begin
      failures++;
      $display("FAIL %s: got busy=%b done=%b pass=%b cs=%b wr=%b a=%h d=%h be=%h err=%h ffa=%h want all 0",
               nm, busy, done, pass, chipselect, write, address, writedata,
               byteenable, error_count, first_fail_addr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base = '0; count = '0; seed = '0;
    #1;
    check_idle_outs("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_good(input logic [AW-1:0] b, input int n,
                           input logic [31:0] s, input string nm);
    int c;
    launch(b, n, s);
    wait_done(nm, c);
    checks++;
    if (c !== 2*n + 2) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", nm, c, 2*n + 2);
    end
    checks++;
    if (pass !== 1'b1 || error_count !== 16'd0) begin
      failures++;
      $display("FAIL %s result: got pass=%b err=%0d want pass=1 err=0",
               nm, pass, error_count);
    end
    check_log(nm, b, n, s);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      failures++;
      $display("FAIL %s after done: got done=%b busy=%b pass=%b want 0 0 1",
               nm, done, busy, pass);
    end
  endtask

  task automatic test_corrupt;
    int c;
    corrupt_en = 1'b1; corrupt_addr = 12'd2;
    launch(12'd0, 8, 32'hA5A5_0000);
    wait_done("corrupt", c);
    checks++;
    if (c !== 18) begin
      failures++;
      $display("FAIL corrupt latency: got %0d want 18", c);
    end
    checks++;
    if (pass !== 1'b0 || error_count !== 16'd1 || first_fail_addr !== 12'd2) begin
      failures++;
      $display("FAIL corrupt result: got pass=%b err=%0d ffa=%h want 0 1 002",
               pass, error_count, first_fail_addr);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_zero;
    int c;
    launch(12'h123, 0, 32'h55);
    wait_done("zero", c);
    checks++;
    if (c !== 1 || pass !== 1'b1 || lw.size() !== 0) begin
      failures++;
      $display("FAIL zero: got cyc=%0d pass=%b cmds=%0d want 1 1 0",
               c, pass, lw.size());
    end
  endtask

  task automatic test_abort;
    launch(12'h040, 16, 32'h7);
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || chipselect !== 1'b0 || write !== 1'b0) begin
      failures++;
      $display("FAIL abort: got busy=%b cs=%b wr=%b want 0 0 0",
               busy, chipselect, write);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (done_seen !== 0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL abort tail: got dones=%0d pass=%b want 0 0",
               done_seen, pass);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    launch(12'h200, 16, 32'h0BAD_0000);
    repeat (2) @(negedge clk);
    start = 1'b1; seed = 32'hFFFF_0000; base = 12'h100;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (address !== 12'h203 || writedata !== 32'h0BAD_0003 || write !== 1'b1) begin
      failures++;
      $display("FAIL start_ignored: got a=%h d=%h wr=%b want 203 0bad0003 1",
               address, writedata, write);
    end
    #2 reset = 1'b1;
    #1;
    check_idle_outs("reset_mid");
    n = lw.size();
    repeat (3) @(negedge clk);
    checks++;
    if (lw.size() !== n) begin
      failures++;
      $display("FAIL reset_mid cmds: got %0d want %0d", lw.size(), n);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_good(12'h000, 4, 32'h0000_1000, "good4");
    test_corrupt;
    test_zero;
    test_good(12'hFFE, 4, 32'hCAFE_0000, "wrap");
    test_abort;
    test_good(12'h010, 3, 32'hFFFF_FFFE, "after_abort");
    test_reset_mid;
    test_good(12'h300, 5, 32'h1234_5678, "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
